// File: rtl/serial_word_rx.sv
// serial_word_rx: deserializes an async-framed serial line (idle 1, start 0,
// DATA_W data bits LSB first, stop 1) into words on a valid/ready handshake.
// Ports:
//   clk       - system clock, rising edge
//   clr       - asynchronous active-low reset
//   sin       - serial line from the flip-flop stage, idle high
//   out_ready - consumer accepts out_data this cycle
//   out_data  - received word, stable while out_valid is high
//   out_valid - out_data holds an unaccepted word
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   overrun   - sticky: a completed word was dropped because out_valid was high
//   busy      - receiver FSM is not idle
module serial_word_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              sin,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t            state, nxt;
    logic              s1, s;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [DATA_W-1:0] sh, sh_nxt;
    logic              done, done_nxt, fe_nxt;
    logic              tick_h, tick;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) {s, s1} <= 2'b11;
        else      {s, s1} <= {s1, sin};
    end

    assign tick_h = cnt == CW'(H - 1);
    assign tick   = cnt == CW'(CLKS_PER_BIT - 1);
    assign busy   = state != IDLE;

    always_comb begin
        nxt      = state;
        cnt_nxt  = cnt + 1'b1;
        idx_nxt  = idx;
        sh_nxt   = sh;
        done_nxt = 1'b0;
        fe_nxt   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!s) nxt = START;
            end
            START: if (tick_h) begin
                cnt_nxt = '0;
                idx_nxt = '0;
                nxt     = s ? IDLE : DATA;
            end
            DATA: if (tick) begin
                cnt_nxt = '0;
                // shift in from the MSB so the first (LSB) bit ends at bit 0
                sh_nxt  = DATA_W'({s, sh} >> 1);
                idx_nxt = idx + 1'b1;
                if (idx == IW'(DATA_W - 1)) nxt = STOP;
            end
            STOP: if (tick) begin
                cnt_nxt  = '0;
                done_nxt = s;
                fe_nxt   = !s;
                nxt      = s ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                cnt_nxt = '0;
                if (s) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            sh        <= sh_nxt;
            done      <= done_nxt;
            frame_err <= fe_nxt;
        end
    end

    // a completed word may load only if the slot is empty or being drained
    // on this very edge; otherwise it is dropped and overrun latches
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (done) begin
            if (!out_valid || out_ready) begin
                out_data  <= sh;
                out_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: scoreboard bench for serial_word_rx; stimulus pushes the
// expected words, a negedge monitor pops and compares on every transfer.
module tb_serial_word_rx;
    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         clr, sin, out_ready;
    logic [W-1:0] out_data;
    logic         out_valid, frame_err, overrun, busy;

    int           compared = 0, mismatched = 0, fe_cnt = 0, fe0, lat;
    logic         any_valid, any_busy;
    logic [W-1:0] sb[$];
    logic [W-1:0] mon_exp;

    serial_word_rx #(.DATA_W(W), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .clr(clr), .sin(sin), .out_ready(out_ready),
        .out_data(out_data), .out_valid(out_valid), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (out_valid && out_ready) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL xfer: got %h, expected no transfer", out_data);
            end else begin
                mon_exp = sb.pop_front();
                if (out_data !== mon_exp) begin
                    mismatched++;
                    $display("FAIL xfer: got %h, expected %h", out_data, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic b, input int n);
        sin = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic stop, input int stop_n, input logic push);
        if (push) sb.push_back(d);
        put(1'b0, C);
        for (int i = 0; i < W; i++) put(d[i], C);
        put(stop, stop_n);
    endtask

    initial begin
        clr = 1'b0; sin = 1'b1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // single frame, latency and hold
        fork
            send(8'hA5, 1'b1, C, 1'b1);
            begin
                @(posedge clk);
                lat = 0;
                do begin
                    @(posedge clk);
                    #1;
                    lat++;
                end while (!out_valid && lat < 200);
            end
        join
        chk("latency", lat, 41);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, 8'hA5);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain_valid", out_valid, 0);

        // one-cycle glitch
        fe0 = fe_cnt;
        put(1'b0, 1);
        put(1'b1, 20);
        chk("glitch_busy", busy, 0);
        chk("glitch_valid", out_valid, 0);
        chk("glitch_fe", fe_cnt - fe0, 0);

        // framing error with stop bit held low
        fe0 = fe_cnt;
        send(8'h3C, 1'b0, 20, 1'b0);
        chk("fe_pulse", fe_cnt - fe0, 1);
        chk("fe_valid", out_valid, 0);
        chk("fe_busy_low", busy, 1);
        put(1'b1, 10);
        chk("fe_busy_idle", busy, 0);

        // overrun: second word dropped
        send(8'h11, 1'b1, C, 1'b1);
        send(8'h22, 1'b1, C, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("ovr_data", out_data, 8'h11);
        chk("ovr_valid", out_valid, 1);
        chk("ovr_flag", overrun, 1);

        // reset mid-frame drops the held word
        put(1'b0, C);
        put(1'b1, C);
        chk("mid_busy", busy, 1);
        #3;
        sb.delete();
        clr = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_ovr", overrun, 0);
        chk("arst_busy", busy, 0);
        chk("arst_fe", frame_err, 0);
        @(posedge clk);
        #1;
        sin = 1'b1;
        clr = 1'b1;
        any_valid = 1'b0; any_busy = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
            any_valid |= out_valid;
            any_busy  |= busy;
        end
        chk("idle_valid", any_valid, 0);
        chk("idle_busy", any_busy, 0);

        // overrun avoided by a transfer on the load edge
        send(8'h11, 1'b1, C, 1'b1);
        fork
            send(8'h22, 1'b1, C, 1'b1);
            begin
                repeat (41) @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        chk("swap_data", out_data, 8'h22);
        chk("swap_valid", out_valid, 1);
        chk("swap_ovr", overrun, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // back-to-back throughput
        fe0 = fe_cnt;
        out_ready = 1'b1;
        send(8'h00, 1'b1, C, 1'b1);
        send(8'hFF, 1'b1, C, 1'b1);
        send(8'h55, 1'b1, C, 1'b1);
        send(8'hAA, 1'b1, C, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("b2b_left", sb.size(), 0);
        chk("b2b_fe", fe_cnt - fe0, 0);
        chk("b2b_ovr", overrun, 0);
        chk("b2b_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
